return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
- Hardware return-address stack (RAS) for the pipelined MIPS core, at the decode stage.
- The link-address adder produces PC+8 for jal/jalr. This block consumes that value: it pushes the link address on a call and supplies the predicted target on jr $ra (pop).
- It lets fetch redirect a return early; the real target is still resolved in execute.

Parameters:
- WIDTH, 32, address width in bits.
- DEPTH, 8, number of entries; must be a power of two and >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- stall  input  1  pipeline stall; while high, push and pop are ignored.
- flush  input  1  clears the stack (exception/eret); takes priority over push and pop.
- push  input  1  call decoded (jal/jalr with rd=31).
- push_addr  input  WIDTH  link address (PC+8) to store.
- pop  input  1  return decoded (jr $ra).
- top_addr  output  WIDTH  predicted return address.
- top_valid  output  1  stack non-empty.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Storage is a circular array mem[DEPTH]. Pointer tp (log2 DEPTH bits) indexes the next free slot; top entry = mem[tp-1] mod DEPTH.
- Reset (reset==0 at a clk edge): tp=0, count=0, overflow=0, underflow=0. mem is not reset.
- Outputs are combinational from state:
  - top_valid = (count!=0).
  - top_addr = mem[tp-1] when count!=0, else 0.
  - A push is visible on top_addr the cycle after the edge; no same-cycle bypass.
- Priority per edge: reset > flush > stall > push/pop.
- flush: tp=0, count=0. Sticky flags are retained.
- Push only:
  - mem[tp]=push_addr, tp=tp+1 (wraps).
  - If count<DEPTH: count=count+1.
  - If count==DEPTH: count stays DEPTH, the oldest entry is silently overwritten, overflow=1.
- Pop only:
  - If count>0: tp=tp-1, count=count-1.
  - If count==0: no state change except underflow=1.
- Push and pop together (call in the slot of a return):
  - If count>0: mem[tp-1]=push_addr (top replaced); tp and count unchanged.
  - If count==0: treated as a push only; underflow is not set.
- push_addr is stored unmodified; there is no alignment check.
- overflow and underflow clear only on reset.

Optional Feature:
- Macro: RAS_MISPRED_CNT_EN.
- When defined, the block adds these ports:
  - resolve_valid  input  1  a jr $ra target was resolved in execute.
  - resolve_addr  input  WIDTH  the resolved target.
  - resolve_pred  input  WIDTH  the predicted target captured at pop time.
  - mispred_cnt  output  32  misprediction counter.
- On resolve_valid with resolve_addr!=resolve_pred, mispred_cnt increments by 1 and saturates at 32'hFFFFFFFF.
- mispred_cnt resets to 0 and is unaffected by flush or stall.
- When the macro is undefined, these ports and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - RAS_DEPTH_DEFAULT = 8.
  - ADDR_W = 32.
  - LINK_OFFSET = 8, which is the constant the link adder uses.
- One sub-module, ras_ptr_ctrl: owns tp, count and the sticky flags, and drives the write enable and write index. The top level holds the storage array and the output muxing.

Test Plan:
- Reset, then push 0x00003008 and push 0x00003108 → count=2, top_addr=0x00003108. Pop → top_addr=0x00003008, count=1.
- Pop on an empty stack → top_valid=0, top_addr=0, underflow=1, count stays 0. A following push of 0x4 → top_addr=0x4.
- Push 9 values 0x10..0x18 with DEPTH=8 → count=8, overflow=1, top_addr=0x18. Eight pops return 0x18 down to 0x11, then top_valid=0.
- With count=2 (top 0x20), assert push=1 of 0x30 and pop=1 together → count=2, top_addr=0x30. The same on an empty stack → count=1, top_addr=0x30, underflow=0.
- stall=1 with push of 0x40 → no change. flush with count=3 → count=0, flags retained. reset low during a push → all state cleared at that edge.
- With RAS_MISPRED_CNT_EN defined, drive three resolves with one mismatch (0x50 vs 0x54) → mispred_cnt=1.

Source files
------------

// File: rtl/return_addr_stack_pkg.sv
// return_addr_stack_pkg: shared constants and operation decode for the return-address stack
package return_addr_stack_pkg;

    localparam int RAS_DEPTH_DEFAULT = 8;
    localparam int ADDR_W            = 32;
    localparam int LINK_OFFSET       = 8;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } ras_op_e;

    // A call in the slot of a return replaces the top, unless there is no top to replace.
    function automatic ras_op_e decode_op(input logic push, input logic pop, input logic empty);
        if (push && pop && !empty) return OP_REPL;
        if (push)                  return OP_PUSH;
        if (pop)                   return OP_POP;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/ras_ptr_ctrl.sv
// ras_ptr_ctrl: stack pointer, occupancy, sticky flags and write control for the return-address stack
module ras_ptr_ctrl
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] tp_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             we_o,
    output logic [PTR_W-1:0] widx_o
);

    logic [PTR_W-1:0] tp_q, tp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             empty, full;
    ras_op_e          op;

    assign empty = count_q == '0;
    assign full  = count_q == CNT_W'(DEPTH);

    // Next state: flush beats stall, stall masks push/pop; a full push wraps over the oldest entry.
    always_comb begin
        op      = (flush_i || stall_i) ? OP_NONE : decode_op(push_i, pop_i, empty);
        tp_d    = tp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (flush_i) begin
            tp_d    = '0;
            count_d = '0;
        end else if (op == OP_PUSH) begin
            tp_d    = tp_q + PTR_W'(1);
            count_d = full ? count_q : count_q + CNT_W'(1);
            ovf_d   = ovf_q | full;
        end else if (op == OP_POP) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                tp_d    = tp_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign we_o        = reset && (op == OP_PUSH || op == OP_REPL);
    assign widx_o      = (op == OP_REPL) ? tp_q - PTR_W'(1) : tp_q;
    assign tp_o        = tp_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: decode-stage return-address stack; optional RAS_MISPRED_CNT_EN adds a misprediction counter
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int WIDTH = ADDR_W,
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] top_addr,
    output logic             top_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
`ifdef RAS_MISPRED_CNT_EN
    ,
    input  logic             resolve_valid,
    input  logic [WIDTH-1:0] resolve_addr,
    input  logic [WIDTH-1:0] resolve_pred,
    output logic [31:0]      mispred_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] tp, widx;
    logic             we;

    ras_ptr_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall),
        .flush_i    (flush),
        .push_i     (push),
        .pop_i      (pop),
        .tp_o       (tp),
        .count_o    (count),
        .overflow_o (overflow),
        .underflow_o(underflow),
        .we_o       (we),
        .widx_o     (widx)
    );

    // Storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (we) mem_q[widx] <= push_addr;
    end

    assign top_valid = count != '0;
    assign top_addr  = top_valid ? mem_q[tp - PTR_W'(1)] : '0;

`ifdef RAS_MISPRED_CNT_EN
    logic [31:0] mispred_q, mispred_d;

    // Count resolved returns whose target differed from the prediction, saturating at all-ones.
    always_comb begin
        mispred_d = (resolve_valid && resolve_addr != resolve_pred && mispred_q != '1) ? mispred_q + 32'd1 : mispred_q;
    end

    // Counter register; only reset clears it, flush and stall do not.
    always_ff @(posedge clk) begin
        if (!reset) mispred_q <= '0;
        else        mispred_q <= mispred_d;
    end

    assign mispred_cnt = mispred_q;
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: table vectors, corner sequences and randomized checks against a queue model
module tb_return_addr_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] push_addr = '0;
    logic [WIDTH-1:0] top_addr;
    logic             top_valid;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
`ifdef RAS_MISPRED_CNT_EN
    logic             resolve_valid = 1'b0;
    logic [WIDTH-1:0] resolve_addr = '0;
    logic [WIDTH-1:0] resolve_pred = '0;
    logic [31:0]      mispred_cnt;
    int               m_mis = 0;
`endif

    return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .push     (push),
        .push_addr(push_addr),
        .pop      (pop),
        .top_addr (top_addr),
        .top_valid(top_valid),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
`ifdef RAS_MISPRED_CNT_EN
        ,
        .resolve_valid(resolve_valid),
        .resolve_addr (resolve_addr),
        .resolve_pred (resolve_pred),
        .mispred_cnt  (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    typedef struct {
        logic        st, fl, pu, po;
        logic [31:0] a;
        int          cnt;
        logic [31:0] top;
        logic        ovf, unf;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stack semantics as a bounded LIFO: newest at the back, oldest dropped when a push overfills it.
    task automatic model_step();
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (flush) begin
            q.delete();
        end else if (!stall) begin
            if (push && pop && q.size() > 0) begin
                q[q.size()-1] = push_addr;
            end else if (push) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1'b1;
                end
                q.push_back(push_addr);
            end else if (pop) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_unf = 1'b1;
            end
        end
`ifdef RAS_MISPRED_CNT_EN
        if (!reset) m_mis = 0;
        else if (resolve_valid && resolve_addr != resolve_pred) m_mis++;
`endif
    endtask

    task automatic cyc(input logic r, input logic st, input logic fl, input logic pu, input logic po,
                       input logic [WIDTH-1:0] a);
        reset = r;
        stall = st;
        flush = fl;
        push = pu;
        pop = po;
        push_addr = a;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, 64'(count), 64'(q.size()));
        check({tag, "_valid"}, 64'(top_valid), 64'(q.size() != 0));
        check({tag, "_top"}, 64'(top_addr), 64'(q.size() != 0 ? q[q.size()-1] : '0));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_unf"}, 64'(underflow), 64'(m_unf));
`ifdef RAS_MISPRED_CNT_EN
        check({tag, "_mis"}, 64'(mispred_cnt), 64'(m_mis));
`endif
    endtask

    initial begin
        tbl[0]  = '{0, 0, 1, 1, 32'h30,   1, 32'h30,   0, 0};
        tbl[1]  = '{0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 0};
        tbl[2]  = '{0, 0, 1, 0, 32'h3008, 1, 32'h3008, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 32'h3108, 2, 32'h3108, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 32'h0,    1, 32'h3008, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 32'h20,   2, 32'h20,   0, 0};
        tbl[6]  = '{0, 0, 1, 1, 32'h30,   2, 32'h30,   0, 0};
        tbl[7]  = '{1, 0, 1, 0, 32'h40,   2, 32'h30,   0, 0};
        tbl[8]  = '{0, 0, 1, 0, 32'h40,   3, 32'h40,   0, 0};
        tbl[9]  = '{0, 1, 1, 0, 32'h44,   0, 32'h0,    0, 0};
        tbl[10] = '{0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 1};
        tbl[11] = '{0, 0, 1, 0, 32'h4,    1, 32'h4,    0, 1};
        tbl[12] = '{1, 0, 0, 1, 32'h0,    1, 32'h4,    0, 1};
        tbl[13] = '{1, 1, 1, 0, 32'h8,    0, 32'h0,    0, 1};

        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, 0, 32'hdead);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(top_valid), 64'd0);
        check("rst_top", 64'(top_addr), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_unf", 64'(underflow), 64'd0);
`ifdef RAS_MISPRED_CNT_EN
        check("rst_mis", 64'(mispred_cnt), 64'd0);
`endif

        for (int i = 0; i < 14; i++) begin
            cyc(1, tbl[i].st, tbl[i].fl, tbl[i].pu, tbl[i].po, tbl[i].a);
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_valid", i), 64'(top_valid), 64'(tbl[i].cnt != 0));
            check($sformatf("tbl%0d_top", i), 64'(top_addr), 64'(tbl[i].top));
            check($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].ovf));
            check($sformatf("tbl%0d_unf", i), 64'(underflow), 64'(tbl[i].unf));
        end

        cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, 0, 32'h10 + 32'(i));
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_top", 64'(top_addr), 64'h18);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop%0d_top", i), 64'(top_addr), 64'(32'h18 - 32'(i)));
            cyc(1, 0, 0, 0, 1, '0);
        end
        check("ovf_drain_valid", 64'(top_valid), 64'd0);
        check("ovf_drain_count", 64'(count), 64'd0);
        check("ovf_drain_unf", 64'(underflow), 64'd0);

        cyc(1, 0, 0, 0, 1, '0);
        cyc(1, 0, 0, 1, 0, 32'h77);
        check("pre_rst_unf", 64'(underflow), 64'd1);
        check("pre_rst_count", 64'(count), 64'd1);
        cyc(0, 0, 0, 1, 0, 32'h99);
        check("rst_push_count", 64'(count), 64'd0);
        check("rst_push_valid", 64'(top_valid), 64'd0);
        check("rst_push_top", 64'(top_addr), 64'd0);
        check("rst_push_ovf", 64'(overflow), 64'd0);
        check("rst_push_unf", 64'(underflow), 64'd0);

`ifdef RAS_MISPRED_CNT_EN
        cyc(1, 0, 0, 0, 0, '0);
        resolve_valid = 1'b1;
        resolve_addr = 32'h50; resolve_pred = 32'h50;
        cyc(1, 0, 0, 0, 0, '0);
        resolve_addr = 32'h50; resolve_pred = 32'h54;
        cyc(1, 0, 1, 0, 0, '0);
        resolve_addr = 32'h60; resolve_pred = 32'h60;
        cyc(1, 1, 0, 0, 0, '0);
        resolve_valid = 1'b0;
        resolve_pred = 32'h0;
        cyc(1, 0, 0, 0, 0, '0);
        check("mis_cnt", 64'(mispred_cnt), 64'd1);
`endif

        cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
`ifdef RAS_MISPRED_CNT_EN
            resolve_valid = $urandom_range(0, 1) == 1;
            resolve_addr = 32'($urandom_range(0, 3));
            resolve_pred = 32'($urandom_range(0, 3));
`endif
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
